// File: rtl/lut4_cfg_sequencer_if.sv
// Configuration bus between the pin-side loader and the LUT write-port sequencer.
interface lut4_cfg_sequencer_if #(
    parameter int ADDR_W = 4
) ();
    logic              i_cfg_start;
    logic              i_cfg_abort;
    logic              i_cfg_bit;
    logic              i_cfg_valid;
    logic              o_cfg_ready;
    logic [ADDR_W-1:0] o_lut_addr;
    logic              o_lut_data;
    logic              o_lut_cfg_en;
    logic              o_busy;
    logic              o_done;
    logic              o_configured;
    logic              o_lut_valid;

    modport master (
        output i_cfg_start, i_cfg_abort, i_cfg_bit, i_cfg_valid,
        input  o_cfg_ready, o_lut_addr, o_lut_data, o_lut_cfg_en,
        input  o_busy, o_done, o_configured, o_lut_valid
    );

    modport slave (
        input  i_cfg_start, i_cfg_abort, i_cfg_bit, i_cfg_valid,
        output o_cfg_ready, o_lut_addr, o_lut_data, o_lut_cfg_en,
        output o_busy, o_done, o_configured, o_lut_valid
    );
endinterface

// File: rtl/lut4_cfg_sequencer.sv
// Shifts in a serial LUT truth table (MSB first) and writes it to the LUT one entry per clock.
module lut4_cfg_sequencer #(
    parameter int LUT_BITS = 16,
    parameter int ADDR_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    lut4_cfg_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StWrite} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [LUT_BITS-1:0] shreg_q, shreg_d;

    logic              cfg_ready_q, cfg_ready_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic              lut_data_q, lut_data_d;
    logic              lut_cfg_en_q, lut_cfg_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              configured_q, configured_d;
    logic              lut_valid_q, lut_valid_d;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LUT_BITS - 1);

    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        wcnt_d       = wcnt_q;
        shreg_d      = shreg_q;
        configured_d = configured_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_cfg_start) begin
                    state_d      = StShift;
                    bcnt_d       = '0;
                    configured_d = 1'b0;
                end
            end
            StShift: begin
                if (bus.i_cfg_abort) begin
                    state_d      = StIdle;
                    configured_d = 1'b0;
                end else if (bus.i_cfg_start) begin
                    bcnt_d = '0;
                end else if (bus.i_cfg_valid && cfg_ready_q) begin
                    shreg_d = {shreg_q[LUT_BITS-2:0], bus.i_cfg_bit};
                    if (bcnt_q == LastIdx) begin
                        state_d = StWrite;
                        wcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                if (bus.i_cfg_abort) begin
                    state_d      = StIdle;
                    configured_d = 1'b0;
                end else if (wcnt_q == LastIdx) begin
                    state_d      = StIdle;
                    done_d       = 1'b1;
                    configured_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state values so each strobe lines up with its state.
        cfg_ready_d  = (state_d == StShift);
        busy_d       = (state_d != StIdle);
        lut_cfg_en_d = (state_d == StWrite);
        lut_addr_d   = lut_addr_q;
        lut_data_d   = lut_data_q;
        if (state_d == StWrite) begin
            lut_addr_d = wcnt_d;
            lut_data_d = shreg_d[wcnt_d];
        end
        lut_valid_d = configured_d & ~busy_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bcnt_q       <= '0;
            wcnt_q       <= '0;
            shreg_q      <= '0;
            cfg_ready_q  <= 1'b0;
            lut_addr_q   <= '0;
            lut_data_q   <= 1'b0;
            lut_cfg_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            configured_q <= 1'b0;
            lut_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            wcnt_q       <= wcnt_d;
            shreg_q      <= shreg_d;
            cfg_ready_q  <= cfg_ready_d;
            lut_addr_q   <= lut_addr_d;
            lut_data_q   <= lut_data_d;
            lut_cfg_en_q <= lut_cfg_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            configured_q <= configured_d;
            lut_valid_q  <= lut_valid_d;
        end
    end

    assign bus.o_cfg_ready  = cfg_ready_q;
    assign bus.o_lut_addr   = lut_addr_q;
    assign bus.o_lut_data   = lut_data_q;
    assign bus.o_lut_cfg_en = lut_cfg_en_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_configured = configured_q;
    assign bus.o_lut_valid  = lut_valid_q;

endmodule

// File: tb/tb_lut4_cfg_sequencer.sv
// Directed bench for lut4_cfg_sequencer: loads, stalls, aborts, restarts and async reset.
module tb_lut4_cfg_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    lut4_cfg_sequencer_if #(.ADDR_W(4)) bus ();

    lut4_cfg_sequencer #(
        .LUT_BITS(16),
        .ADDR_W  (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Write-port monitor, sampled mid-cycle.
    logic [15:0] wtable    = '0;
    logic [3:0]  exp_addr  = '0;
    int          strobe_cnt = 0;
    int          seq_err    = 0;
    int          done_cnt   = 0;
    int          done_cyc   = 0;

    always @(negedge clk) begin
        if (bus.o_lut_cfg_en) begin
            if (bus.o_lut_addr != exp_addr) seq_err++;
            if (bus.o_cfg_ready) seq_err++;
            wtable[bus.o_lut_addr] = bus.o_lut_data;
            exp_addr = exp_addr + 4'd1;
            strobe_cnt++;
        end else begin
            exp_addr = '0;
            if (bus.o_busy && !bus.o_cfg_ready) seq_err++;
        end
        if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] outs();
        return {bus.o_cfg_ready, bus.o_lut_addr, bus.o_lut_data, bus.o_lut_cfg_en,
                bus.o_busy, bus.o_done, bus.o_configured, bus.o_lut_valid};
    endfunction

    task automatic pulse_start(output int c0);
        c0 = cyc;
        bus.i_cfg_start = 1'b1;
        step();
        bus.i_cfg_start = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] d, input int nbits, input bit gap);
        for (int i = 0; i < nbits; i++) begin
            bus.i_cfg_valid = 1'b1;
            bus.i_cfg_bit   = d[15-i];
            step();
            if (gap) begin
                bus.i_cfg_valid = 1'b0;
                step();
            end
        end
        bus.i_cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (bus.o_busy && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
        step();
    endtask

    task automatic wait_addr(input string tag, input logic [3:0] a, input int max);
        int n = 0;
        while (!(bus.o_lut_cfg_en && bus.o_lut_addr == a) && n < max) begin
            step();
            n++;
        end
        check(tag, 32'(n < max), 32'd1);
    endtask

    int c0, s0, d0, e0;

    initial begin
        rst_n           = 1'b0;
        bus.i_cfg_start = 1'b0;
        bus.i_cfg_abort = 1'b0;
        bus.i_cfg_bit   = 1'b0;
        bus.i_cfg_valid = 1'b0;
        #1;
        check("reset_outs", 32'(outs()), 32'd0);
        #12 rst_n = 1'b1;
        step();
        check("idle_outs", 32'(outs()), 32'd0);

        // Back-to-back load of 0xA5C3.
        s0 = strobe_cnt; d0 = done_cnt; e0 = seq_err;
        pulse_start(c0);
        check("shift_ready", 32'({bus.o_cfg_ready, bus.o_busy}), 32'b11);
        send_bits(16'hA5C3, 16, 1'b0);
        check("first_strobe", 32'({bus.o_lut_cfg_en, bus.o_lut_addr, bus.o_cfg_ready}),
              32'b1_0000_0);
        wait_idle("t1_timeout", 40);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd16);
        check("t1_table", 32'(wtable), 32'hA5C3);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t1_latency", 32'(done_cyc - c0), 32'd33);
        check("t1_seq", 32'(seq_err - e0), 32'd0);
        check("t1_cfg_valid", 32'({bus.o_configured, bus.o_lut_valid, bus.o_busy}), 32'b110);

        // Abort while idle must keep the table valid.
        bus.i_cfg_abort = 1'b1;
        step();
        bus.i_cfg_abort = 1'b0;
        step();
        check("idle_abort", 32'({bus.o_configured, bus.o_lut_valid}), 32'b11);

        // Stalled load: valid toggles every other cycle.
        s0 = strobe_cnt; d0 = done_cnt; e0 = seq_err;
        wtable = '0;
        pulse_start(c0);
        check("t2_cfg_cleared", 32'({bus.o_configured, bus.o_lut_valid}), 32'b00);
        send_bits(16'hA5C3, 16, 1'b1);
        wait_idle("t2_timeout", 40);
        check("t2_table", 32'(wtable), 32'hA5C3);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd16);
        check("t2_latency", 32'(done_cyc - c0), 32'd48);
        check("t2_seq", 32'(seq_err - e0), 32'd0);
        check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Abort after 8 bits, with a valid bit in the abort cycle.
        s0 = strobe_cnt; d0 = done_cnt;
        pulse_start(c0);
        send_bits(16'hFFFF, 8, 1'b0);
        bus.i_cfg_abort = 1'b1;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_bit   = 1'b1;
        step();
        bus.i_cfg_abort = 1'b0;
        bus.i_cfg_valid = 1'b0;
        check("t3_idle", 32'({bus.o_cfg_ready, bus.o_busy, bus.o_configured, bus.o_lut_valid}),
              32'b0000);
        repeat (20) step();
        check("t3_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        check("t3_no_done", 32'(done_cnt - d0), 32'd0);

        // Abort during write-back at address 7, then a full 0xFFFF load.
        s0 = strobe_cnt; d0 = done_cnt;
        pulse_start(c0);
        send_bits(16'h1234, 16, 1'b0);
        wait_addr("t4_addr7", 4'd7, 20);
        bus.i_cfg_abort = 1'b1;
        step();
        bus.i_cfg_abort = 1'b0;
        check("t4_abort_outs", 32'({bus.o_lut_cfg_en, bus.o_busy, bus.o_configured}), 32'b000);
        repeat (3) step();
        check("t4_strobes", 32'(strobe_cnt - s0), 32'd8);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        s0 = strobe_cnt; wtable = '0;
        pulse_start(c0);
        send_bits(16'hFFFF, 16, 1'b0);
        wait_idle("t4b_timeout", 40);
        check("t4b_table", 32'(wtable), 32'hFFFF);
        check("t4b_strobes", 32'(strobe_cnt - s0), 32'd16);
        check("t4b_cfg", 32'(bus.o_configured), 32'd1);

        // Restart mid-shift, then a start pulse during write-back.
        s0 = strobe_cnt; d0 = done_cnt; e0 = seq_err;
        pulse_start(c0);
        send_bits(16'hFFFF, 5, 1'b0);
        bus.i_cfg_start = 1'b1;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_bit   = 1'b1;
        step();
        bus.i_cfg_start = 1'b0;
        bus.i_cfg_valid = 1'b0;
        send_bits(16'h0001, 16, 1'b0);
        wait_addr("t5_addr3", 4'd3, 20);
        bus.i_cfg_start = 1'b1;
        step();
        bus.i_cfg_start = 1'b0;
        wait_idle("t5_timeout", 40);
        check("t5_table", 32'(wtable), 32'h0001);
        check("t5_strobes", 32'(strobe_cnt - s0), 32'd16);
        check("t5_seq", 32'(seq_err - e0), 32'd0);
        check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("t5_cfg", 32'({bus.o_configured, bus.o_lut_valid}), 32'b11);

        // Asynchronous reset during write-back at address 10.
        pulse_start(c0);
        send_bits(16'h5A5A, 16, 1'b0);
        wait_addr("t6_addr10", 4'd10, 20);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_outs", 32'(outs()), 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        check("t6_post_outs", 32'(outs()), 32'd0);
        bus.i_cfg_valid = 1'b1;
        step();
        bus.i_cfg_valid = 1'b0;
        check("t6_still_idle", 32'({bus.o_cfg_ready, bus.o_busy, bus.o_configured}), 32'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lut4_cfg_sequencer.md
Name: lut4_cfg_sequencer

Overview:
Configuration controller for the 16-entry 4-input LUT cell. It accepts a 16-bit truth table as a serial bit stream with a valid/ready handshake. It then sequences the LUT's write port (address, data, config enable) through all 16 entries, one per clock, and flags when the LUT holds a complete, valid table. It sits between the chip I/O pins and the LUT cell.

Parameters:
LUT_BITS, 16, number of LUT entries (truth-table bits)
ADDR_W, 4, LUT address width; LUT_BITS = 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
i_cfg_start  input  1  start a new configuration load (sampled only in IDLE/SHIFT)
i_cfg_abort  input  1  abort any load in progress
i_cfg_bit  input  1  serial truth-table bit
i_cfg_valid  input  1  i_cfg_bit valid this cycle
o_cfg_ready  output  1  sequencer accepts a bit this cycle
o_lut_addr  output  ADDR_W  LUT write address
o_lut_data  output  1  LUT write data
o_lut_cfg_en  output  1  LUT config enable (write strobe)
o_busy  output  1  load or write-back in progress
o_done  output  1  one-cycle pulse: table fully written
o_configured  output  1  sticky: LUT holds a complete table
o_lut_valid  output  1  LUT output may be used (o_configured and not busy)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0. The shift register and counters are 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, SHIFT, WRITE.
- IDLE:
  - o_cfg_ready=0, o_busy=0.
  - i_cfg_start=1 -> SHIFT next cycle, bit counter=0, o_configured cleared to 0.
- SHIFT:
  - o_cfg_ready=1, o_busy=1.
  - Bit acceptance: a bit is accepted when i_cfg_valid=1 in a cycle where o_cfg_ready=1.
  - Accepted bit: shreg <= {shreg[LUT_BITS-2:0], i_cfg_bit}; counter increments.
  - Bit order is MSB-first: the first accepted bit ends in shreg[15], i.e. LUT entry 15.
  - On the cycle the 16th bit is accepted: -> WRITE next cycle, o_cfg_ready drops to 0 that next cycle, write counter=0.
  - i_cfg_valid=0 stalls; there is no timeout.
  - i_cfg_start=1 in SHIFT: bit counter resets to 0 and any bit presented that cycle is discarded. Earlier bits are overwritten by subsequent shifts.
- WRITE:
  - o_cfg_ready=0, o_busy=1.
  - Each cycle: o_lut_cfg_en=1, o_lut_addr=wcnt, o_lut_data=shreg[wcnt], for wcnt=0..15 ascending.
  - Timing: 16 consecutive strobe cycles; the first strobe is the cycle after the last bit is accepted.
  - After the wcnt=15 cycle: -> IDLE; o_lut_cfg_en=0, o_done=1 for exactly one cycle, o_configured=1.
  - i_cfg_start is ignored in WRITE.
- Abort:
  - i_cfg_abort=1 in SHIFT or WRITE -> IDLE next cycle. o_lut_cfg_en=0, o_busy=0, o_configured=0, no o_done.
  - A partially written LUT is treated as invalid.
  - Abort has priority over start and over bit acceptance in the same cycle.
  - Abort in IDLE has no effect; o_configured is preserved.
- o_lut_valid = o_configured & ~o_busy, registered.
- Counters saturate by state transition; they never wrap while a state is active.
- o_lut_addr and o_lut_data hold their last value when o_lut_cfg_en=0; this is don't-care for the LUT.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. The LUT contents are then undefined to the system (o_configured=0).
- Total latency, start to o_done: 1 (start) + N valid-bit cycles (>=16) + 16 write cycles.

Test Plan:
- Reset, then start, then 16 back-to-back bits 0xA5C3 MSB-first -> 16 strobes with addr 0..15 and data = bit[addr] of 0xA5C3. o_done pulses once on the cycle after addr 15. o_configured=1, o_lut_valid=1. Total 33 cycles from start to o_done.
- Same load with i_cfg_valid toggling every other cycle -> 16 bits accepted over 32 cycles; written table is still 0xA5C3; o_cfg_ready=1 throughout SHIFT.
- Abort after 8 accepted bits -> IDLE next cycle, no o_lut_cfg_en ever asserted, o_configured=0, o_done never pulses.
- Abort at write addr 7 -> strobes 0..7 only, o_configured=0. A following full load of 0xFFFF -> o_configured=1, all 16 data=1.
- Restart: start, 5 bits, start again, then 16 bits of 0x0001 -> written table is 0x0001 (only addr 0 data=1). Start pulsed during WRITE -> ignored, strobe sequence unchanged.
- rst_n low during WRITE at addr 10 -> outputs 0 immediately (asynchronous). After release, state IDLE, o_configured=0.
